cpu_run_ctrl: RTL

CPU_RUN_CTRL -- requirements
Module: cpu_run_ctrl

---
 rtl/cpu_run_pkg.sv | 43 ++++
 rtl/cpu_stall_det.sv | 67 ++++++
 rtl/cpu_run_ctrl.sv | 138 +++++++++++++
 3 files changed

// File: rtl/cpu_run_pkg.sv
// Shared types and defaults for the CPU run controller.
// State encoding is fixed: IDLE=0, RESET=1, RUN=2, DONE=3.
package cpu_run_pkg;

    localparam int DEF_PC_W        = 32;
    localparam int DEF_CNT_W       = 16;
    localparam int DEF_RST_CYCLES  = 2;
    localparam int DEF_MAX_CYCLES  = 50;
    localparam int DEF_STALL_LIMIT = 4;

    localparam int RST_CNT_W   = 8;
    localparam int STALL_CNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RESET = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } run_state_e;

    typedef struct packed {
        logic cpu_rst;
        logic cpu_en;
        logic running;
        logic done;
    } run_ctl_t;

    // Control outputs implied by a given state; registered by the caller.
    function automatic run_ctl_t ctl_for(input run_state_e s);
        run_ctl_t c;
        c = '0;
        unique case (s)
            ST_IDLE, ST_RESET: c.cpu_rst = 1'b1;
            ST_RUN: begin
                c.cpu_en  = 1'b1;
                c.running = 1'b1;
            end
            ST_DONE: c.done = 1'b1;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/cpu_stall_det.sv
// PC-stall detector: flags a stall once the PC has repeated for STALL_LIMIT cycles.
// Only built when CPU_RUN_CTRL_STALL_DETECT_EN is defined.
`ifdef CPU_RUN_CTRL_STALL_DETECT_EN
module cpu_stall_det
    import cpu_run_pkg::*;
#(
    parameter int PC_W        = DEF_PC_W,
    parameter int STALL_LIMIT = DEF_STALL_LIMIT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr_i,
    input  logic            run_i,
    input  logic [PC_W-1:0] pc_i,
    output logic            stall,
    output logic            enable
);

    localparam logic [STALL_CNT_W-1:0] LIMIT_M1 = STALL_CNT_W'(STALL_LIMIT - 1);

    logic [PC_W-1:0]        prev_pc_q, prev_pc_d;
    logic [STALL_CNT_W-1:0] cnt_q, cnt_d;
    logic                   armed_q, armed_d;
    logic                   same;

    // cnt_q holds the number of earlier consecutive repeats, so the current
    // repeat completes the streak when cnt_q reaches STALL_LIMIT-1.
    always_comb begin
        same      = armed_q && (pc_i == prev_pc_q);
        prev_pc_d = prev_pc_q;
        armed_d   = armed_q;
        cnt_d     = cnt_q;
        stall     = 1'b0;
        if (clr_i) begin
            prev_pc_d = '0;
            armed_d   = 1'b0;
            cnt_d     = '0;
        end else if (run_i) begin
            prev_pc_d = pc_i;
            armed_d   = 1'b1;
            if (same) begin
                stall = (cnt_q >= LIMIT_M1);
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + STALL_CNT_W'(1);
                end
            end else begin
                cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_pc_q <= '0;
            armed_q   <= 1'b0;
            cnt_q     <= '0;
        end else begin
            prev_pc_q <= prev_pc_d;
            armed_q   <= armed_d;
            cnt_q     <= cnt_d;
        end
    end

    assign enable = armed_q;

endmodule
`endif

// File: rtl/cpu_run_ctrl.sv
// Run controller: resets a CPU, lets it run until halt/stall or cycle budget, then freezes it.
// Define CPU_RUN_CTRL_STALL_DETECT_EN to also end a run on a repeated PC.
module cpu_run_ctrl
    import cpu_run_pkg::*;
#(
    parameter int PC_W        = DEF_PC_W,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int RST_CYCLES  = DEF_RST_CYCLES,
    parameter int MAX_CYCLES  = DEF_MAX_CYCLES,
    parameter int STALL_LIMIT = DEF_STALL_LIMIT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [PC_W-1:0]  cpu_pc,
    input  logic             cpu_halt,
    output logic             cpu_rst,
    output logic             cpu_en,
    output logic             running,
    output logic             done,
    output logic             halted,
    output logic             timeout,
    output logic [CNT_W-1:0] cycle_count,
    output logic [PC_W-1:0]  last_pc
);

    localparam logic [RST_CNT_W-1:0] RST_LAST = RST_CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]     MAX_C    = CNT_W'(MAX_CYCLES);

    run_state_e           state_q, state_d;
    run_ctl_t             ctl_q, ctl_d;
    logic [RST_CNT_W-1:0] rst_cnt_q, rst_cnt_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [PC_W-1:0]      last_pc_q, last_pc_d;
    logic                 halted_q, halted_d;
    logic                 timeout_q, timeout_d;
    logic                 enter_reset;
    logic                 stall_hit;

    assign enter_reset = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

`ifdef CPU_RUN_CTRL_STALL_DETECT_EN
    logic stall;
    logic det_en;

    cpu_stall_det #(
        .PC_W        (PC_W),
        .STALL_LIMIT (STALL_LIMIT)
    ) u_stall_det (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (enter_reset),
        .run_i  (state_q == ST_RUN),
        .pc_i   (cpu_pc),
        .stall  (stall),
        .enable (det_en)
    );

    assign stall_hit = stall & det_en;
`else
    logic unused_stall_cfg;
    assign unused_stall_cfg = ^(STALL_CNT_W'(STALL_LIMIT));
    assign stall_hit        = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        rst_cnt_d = rst_cnt_q;
        cnt_d     = cnt_q;
        last_pc_d = last_pc_q;
        halted_d  = halted_q;
        timeout_d = timeout_q;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (enter_reset) begin
                    state_d   = ST_RESET;
                    rst_cnt_d = '0;
                    cnt_d     = '0;
                    last_pc_d = '0;
                    halted_d  = 1'b0;
                    timeout_d = 1'b0;
                end
            end
            ST_RESET: begin
                if (rst_cnt_q == RST_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    rst_cnt_d = rst_cnt_q + RST_CNT_W'(1);
                end
            end
            ST_RUN: begin
                last_pc_d = cpu_pc;
                if (cnt_q < MAX_C) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                // Halt wins over budget exhaustion in the same cycle.
                if (cpu_halt || stall_hit) begin
                    state_d  = ST_DONE;
                    halted_d = 1'b1;
                end else if (cnt_d == MAX_C) begin
                    state_d   = ST_DONE;
                    timeout_d = 1'b1;
                end
            end
        endcase
        ctl_d = ctl_for(state_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            ctl_q     <= ctl_for(ST_IDLE);
            rst_cnt_q <= '0;
            cnt_q     <= '0;
            last_pc_q <= '0;
            halted_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ctl_q     <= ctl_d;
            rst_cnt_q <= rst_cnt_d;
            cnt_q     <= cnt_d;
            last_pc_q <= last_pc_d;
            halted_q  <= halted_d;
            timeout_q <= timeout_d;
        end
    end

    assign cpu_rst     = ctl_q.cpu_rst;
    assign cpu_en      = ctl_q.cpu_en;
    assign running     = ctl_q.running;
    assign done        = ctl_q.done;
    assign halted      = halted_q;
    assign timeout     = timeout_q;
    assign cycle_count = cnt_q;
    assign last_pc     = last_pc_q;

endmodule
